// File: rtl/demux12_stream.sv
// 1-to-2 valid/ready stream demultiplexer with the route locked per packet and
// a one-entry registered slot per output. Optional beat counters: DEMUX12_STREAM_COUNT_EN.
module demux12_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready,
`ifdef DEMUX12_STREAM_COUNT_EN
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1,
`endif
  output logic             busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             locked_sel_q, locked_sel_d;
  logic [WIDTH-1:0] out0_data_q, out0_data_d, out1_data_q, out1_data_d;
  logic             out0_last_q, out0_last_d, out1_last_q, out1_last_d;
  logic             out0_valid_q, out0_valid_d, out1_valid_q, out1_valid_d;
  logic             tgt_s, tgt_valid_s, tgt_ready_s, acc_s, acc0_s, acc1_s;

  // Target channel selection and input handshake; only the target slot gates the input.
  always_comb begin
    tgt_s       = (state_q == ST_PKT) ? locked_sel_q : in_sel;
    tgt_valid_s = tgt_s ? out1_valid_q : out0_valid_q;
    tgt_ready_s = tgt_s ? out1_ready : out0_ready;
    in_ready    = !tgt_valid_s || tgt_ready_s;
    acc_s       = in_valid && in_ready;
    acc0_s      = acc_s && !tgt_s;
    acc1_s      = acc_s && tgt_s;
  end

  // Packet framing FSM: the route is captured on the first beat of a multi-beat packet.
  always_comb begin
    state_d      = state_q;
    locked_sel_d = locked_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_s && !in_last) begin
          state_d      = ST_PKT;
          locked_sel_d = in_sel;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PKT: begin
        if (acc_s && in_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PKT;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        locked_sel_d = 1'b0;
      end
    endcase
  end

  // Output slots: a load wins over a drain so back-to-back beats leave no bubble.
  always_comb begin
    out0_data_d  = out0_data_q;
    out0_last_d  = out0_last_q;
    out0_valid_d = out0_valid_q;
    out1_data_d  = out1_data_q;
    out1_last_d  = out1_last_q;
    out1_valid_d = out1_valid_q;
    if (acc0_s) begin
      out0_data_d  = in_data;
      out0_last_d  = in_last;
      out0_valid_d = 1'b1;
    end else if (out0_ready) begin
      out0_valid_d = 1'b0;
    end else begin
      out0_valid_d = out0_valid_q;
    end
    if (acc1_s) begin
      out1_data_d  = in_data;
      out1_last_d  = in_last;
      out1_valid_d = 1'b1;
    end else if (out1_ready) begin
      out1_valid_d = 1'b0;
    end else begin
      out1_valid_d = out1_valid_q;
    end
  end

  // State and slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      locked_sel_q <= 1'b0;
      out0_data_q  <= {WIDTH{1'b0}};
      out0_last_q  <= 1'b0;
      out0_valid_q <= 1'b0;
      out1_data_q  <= {WIDTH{1'b0}};
      out1_last_q  <= 1'b0;
      out1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      locked_sel_q <= locked_sel_d;
      out0_data_q  <= out0_data_d;
      out0_last_q  <= out0_last_d;
      out0_valid_q <= out0_valid_d;
      out1_data_q  <= out1_data_d;
      out1_last_q  <= out1_last_d;
      out1_valid_q <= out1_valid_d;
    end
  end

  assign out0_data  = out0_data_q;
  assign out0_last  = out0_last_q;
  assign out0_valid = out0_valid_q;
  assign out1_data  = out1_data_q;
  assign out1_last  = out1_last_q;
  assign out1_valid = out1_valid_q;
  assign busy       = (state_q == ST_PKT);

`ifdef DEMUX12_STREAM_COUNT_EN
  logic [15:0] cnt0_q, cnt1_q;

  // Per-channel accepted-beat counters, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      cnt0_q <= cnt0_q + {15'd0, acc0_s};
      cnt1_q <= cnt1_q + {15'd0, acc1_s};
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux12_stream.sv
// Self-checking bench for demux12_stream: directed vector table, reset-mid-packet
// sequence, randomized run against a queue-based model, and optional counter checks.
module tb_demux12_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_sel = 1'b0, in_last = 1'b0, in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out0_data, out1_data;
  logic       out0_last, out0_valid, out1_last, out1_valid;
  logic       out0_ready = 1'b1, out1_ready = 1'b1;
  logic       busy;
`ifdef DEMUX12_STREAM_COUNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int n_vec = 0;
  int n_err = 0;

  demux12_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_last(out0_last),
    .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_last(out1_last),
    .out1_valid(out1_valid), .out1_ready(out1_ready),
`ifdef DEMUX12_STREAM_COUNT_EN
    .cnt0(cnt0), .cnt1(cnt1),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic l, input logic [7:0] d,
                       input logic r0, input logic r1);
    in_valid = v; in_sel = s; in_last = l; in_data = d;
    out0_ready = r0; out1_ready = r1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  typedef struct {
    logic v; logic sel; logic last; logic [7:0] d; logic r0; logic r1;
    logic rdy;
    logic o0v; logic [7:0] o0d; logic o0l;
    logic o1v; logic [7:0] o1d; logic o1l;
    logic busy;
  } vec_t;

  vec_t tbl[18];

  // queue-based reference model state
  logic [8:0] slot_q[2][$];
  logic       m_open, m_lock;

  initial begin
    // v sel last data r0 r1 | rdy | o0v o0d o0l | o1v o1d o1l | busy
    tbl[0]  = '{1'b1,1'b0,1'b1,8'h11,1'b1,1'b1, 1'b1, 1'b1,8'h11,1'b1, 1'b0,8'h00,1'b0, 1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b1,8'h22,1'b1,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b1,8'h22,1'b1, 1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b0,8'hA0,1'b1,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b1,8'hA0,1'b0, 1'b1};
    tbl[4]  = '{1'b1,1'b0,1'b0,8'hA1,1'b1,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b1,8'hA1,1'b0, 1'b1};
    tbl[5]  = '{1'b1,1'b0,1'b1,8'hA2,1'b1,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b1,8'hA2,1'b1, 1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b0,8'h01,1'b0,1'b1, 1'b1, 1'b1,8'h01,1'b0, 1'b0,8'h00,1'b0, 1'b1};
    tbl[8]  = '{1'b1,1'b1,1'b1,8'h02,1'b0,1'b1, 1'b0, 1'b1,8'h01,1'b0, 1'b0,8'h00,1'b0, 1'b1};
    tbl[9]  = '{1'b1,1'b1,1'b1,8'h02,1'b0,1'b1, 1'b0, 1'b1,8'h01,1'b0, 1'b0,8'h00,1'b0, 1'b1};
    tbl[10] = '{1'b1,1'b0,1'b1,8'h02,1'b1,1'b1, 1'b1, 1'b1,8'h02,1'b1, 1'b0,8'h00,1'b0, 1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b0};
    tbl[12] = '{1'b1,1'b1,1'b1,8'h55,1'b1,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b1,8'h55,1'b1, 1'b0};
    tbl[13] = '{1'b1,1'b0,1'b0,8'h60,1'b1,1'b0, 1'b1, 1'b1,8'h60,1'b0, 1'b1,8'h55,1'b1, 1'b1};
    tbl[14] = '{1'b1,1'b1,1'b0,8'h61,1'b1,1'b0, 1'b1, 1'b1,8'h61,1'b0, 1'b1,8'h55,1'b1, 1'b1};
    tbl[15] = '{1'b1,1'b1,1'b1,8'h62,1'b1,1'b0, 1'b1, 1'b1,8'h62,1'b1, 1'b1,8'h55,1'b1, 1'b0};
    tbl[16] = '{1'b0,1'b1,1'b0,8'h00,1'b1,1'b0, 1'b0, 1'b0,8'h00,1'b0, 1'b1,8'h55,1'b1, 1'b0};
    tbl[17] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0, 1'b0};

    // reset state
    #3;
    chk("rst_o0v", {15'd0, out0_valid}, 16'd0);
    chk("rst_o1v", {15'd0, out1_valid}, 16'd0);
    chk("rst_o0d", {8'd0, out0_data}, 16'd0);
    chk("rst_o1d", {8'd0, out1_data}, 16'd0);
    chk("rst_o0l", {15'd0, out0_last}, 16'd0);
    chk("rst_o1l", {15'd0, out1_last}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    #9 rst_n = 1'b1;
    #1 chk("rel_rdy", {15'd0, in_ready}, 16'd1);

    // directed table
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].last, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #2 chk($sformatf("t%0d_rdy", i), {15'd0, in_ready}, {15'd0, tbl[i].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_o0v", i), {15'd0, out0_valid}, {15'd0, tbl[i].o0v});
      chk($sformatf("t%0d_o1v", i), {15'd0, out1_valid}, {15'd0, tbl[i].o1v});
      chk($sformatf("t%0d_busy", i), {15'd0, busy}, {15'd0, tbl[i].busy});
      if (tbl[i].o0v) begin
        chk($sformatf("t%0d_o0d", i), {7'd0, out0_last, out0_data}, {7'd0, tbl[i].o0l, tbl[i].o0d});
      end
      if (tbl[i].o1v) begin
        chk($sformatf("t%0d_o1d", i), {7'd0, out1_last, out1_data}, {7'd0, tbl[i].o1l, tbl[i].o1d});
      end
    end

    // reset mid-packet, then a new packet routes by its own select
    drive(1'b1, 1'b1, 1'b0, 8'hB0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 8'hB1, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("mid_busy_pre", {15'd0, busy}, 16'd1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_o0v", {15'd0, out0_valid}, 16'd0);
    chk("mid_o1v", {15'd0, out1_valid}, 16'd0);
    chk("mid_busy", {15'd0, busy}, 16'd0);
    #3 rst_n = 1'b1;
    #1 chk("mid_rdy", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("mid_o0", {7'd0, out0_valid, out0_data}, {7'd0, 1'b1, 8'hC0});
    chk("mid_o1v_after", {15'd0, out1_valid}, 16'd0);
    chk("mid_busy_after", {15'd0, busy}, 16'd0);

    // randomized run against the model
    do_reset();
    slot_q[0].delete(); slot_q[1].delete();
    m_open = 1'b0; m_lock = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic v, s, l, r0, r1, tgt, rdy, acc;
      logic [7:0] d;
      logic rr[2];
      v  = ($urandom_range(0, 3) != 0);
      s  = 1'($urandom_range(0, 1));
      l  = ($urandom_range(0, 3) == 0);
      d  = 8'($urandom);
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      drive(v, s, l, d, r0, r1);
      rr[0] = r0; rr[1] = r1;
      tgt = m_open ? m_lock : s;
      rdy = (slot_q[tgt].size() == 0) || rr[tgt];
      acc = v && rdy;
      #2 chk("rnd_rdy", {15'd0, in_ready}, {15'd0, rdy});
      @(posedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        if (rr[ch] && slot_q[ch].size() > 0) void'(slot_q[ch].pop_front());
      end
      if (acc) begin
        slot_q[tgt].push_back({l, d});
        if (!m_open && !l) begin
          m_open = 1'b1; m_lock = s;
        end else if (m_open && l) begin
          m_open = 1'b0;
        end
      end
      #1;
      chk("rnd_o0v", {15'd0, out0_valid}, {15'd0, slot_q[0].size() > 0});
      chk("rnd_o1v", {15'd0, out1_valid}, {15'd0, slot_q[1].size() > 0});
      chk("rnd_busy", {15'd0, busy}, {15'd0, m_open});
      if (slot_q[0].size() > 0) chk("rnd_o0d", {7'd0, out0_last, out0_data}, {7'd0, slot_q[0][0]});
      if (slot_q[1].size() > 0) chk("rnd_o1d", {7'd0, out1_last, out1_data}, {7'd0, slot_q[1][0]});
    end

`ifdef DEMUX12_STREAM_COUNT_EN
    do_reset();
    chk("cnt0_rst", cnt0, 16'd0);
    chk("cnt1_rst", cnt1, 16'd0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, (k >= 5), 1'b1, 8'(k), 1'b1, 1'b1);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("cnt0_5", cnt0, 16'd5);
    chk("cnt1_3", cnt1, 16'd3);
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    repeat (65536) @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("cnt1_wrap", cnt1, 16'd0);
    chk("cnt0_wrap", cnt0, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
